// File: rtl/rmt_pkg.sv
// Shared types and constants for the rmt_match_router datapath.
// Contents: FSM state encoding, default header offsets and match values,
// table key struct, statistics counter width and a saturating increment.
package rmt_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFwd  = 2'd1,
        StDrop = 2'd2
    } rmt_state_e;

    localparam int unsigned RMT_FUNC_WIDTH   = 16;
    localparam int unsigned RMT_ETYPE_OFFSET = 12;
    localparam int unsigned RMT_DELIM_OFFSET = 42;
    localparam int unsigned RMT_FUNC_OFFSET  = 44;
    localparam logic [15:0] RMT_ETYPE_MATCH  = 16'h0008;  // IPv4, wire byte order
    localparam logic [15:0] RMT_DELIM_MATCH  = 16'hF0E1;

    localparam int unsigned STAT_WIDTH = 32;

    typedef struct packed {
        logic                      valid;
        logic [RMT_FUNC_WIDTH-1:0] func;
    } rmt_key_t;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rmt_match_table.sv
// Runtime-programmable match table: TABLE_DEPTH entries of {valid, func, dest}.
// Ports:
//   clk, rst              clock, synchronous active-high reset (all entries invalid)
//   wr_en/wr_addr         write strobe and entry index; write lands on the next edge
//   wr_valid/func/dest    entry contents
//   lookup_func           key to search for
//   hit/hit_dest          combinational result; lowest-index valid match wins
module rmt_match_table
    import rmt_pkg::*;
#(
    parameter int unsigned TABLE_DEPTH = 4,
    parameter int unsigned DEST_WIDTH  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [$clog2(TABLE_DEPTH)-1:0]   wr_addr,
    input  logic                             wr_valid,
    input  logic [RMT_FUNC_WIDTH-1:0]        wr_func,
    input  logic [DEST_WIDTH-1:0]            wr_dest,
    input  logic [RMT_FUNC_WIDTH-1:0]        lookup_func,
    output logic                             hit,
    output logic [DEST_WIDTH-1:0]            hit_dest
);
    localparam int unsigned AW = $clog2(TABLE_DEPTH);

    rmt_key_t              key_q  [TABLE_DEPTH];
    logic [DEST_WIDTH-1:0] dest_q [TABLE_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                key_q[i]  <= '0;
                dest_q[i] <= '0;
            end
        end else if (wr_en) begin
            // Out-of-range addresses (non power-of-two depth) are ignored.
            for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
                if (wr_addr == AW'(i)) begin
                    key_q[i]  <= '{valid: wr_valid, func: wr_func};
                    dest_q[i] <= wr_dest;
                end
            end
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_dest = '0;
        for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
            if (!hit && key_q[i].valid && (key_q[i].func == lookup_func)) begin
                hit      = 1'b1;
                hit_dest = dest_q[i];
            end
        end
    end

endmodule

// File: rtl/rmt_match_router.sv
// AXI-Stream ingress classifier/router. The first beat of each frame is
// checked for EtherType and delimiter, its function-type field is looked up
// in rmt_match_table, and the whole frame is forwarded with a per-frame tdest
// or dropped. One output register stage; no combinational s_axis->m_axis path.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_axis_*          ingress stream (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_*          egress stream plus tdest, constant across a frame
//   cfg_*             match table write port (wr_en, addr, valid, func, dest)
// Optional build macro RMT_STATS_EN adds stat_clr and the saturating
// stat_fwd_pkts / stat_drop_pkts / stat_miss_pkts frame counters.
module rmt_match_router
    import rmt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH   = 2,
    parameter int unsigned TABLE_DEPTH  = 4,
    parameter int unsigned ETYPE_OFFSET = RMT_ETYPE_OFFSET,
    parameter int unsigned DELIM_OFFSET = RMT_DELIM_OFFSET,
    parameter int unsigned FUNC_OFFSET  = RMT_FUNC_OFFSET,
    parameter logic [15:0] ETYPE_MATCH  = RMT_ETYPE_MATCH,
    parameter logic [15:0] DELIM_MATCH  = RMT_DELIM_MATCH,
    parameter int unsigned MISS_DROP    = 0,
    parameter int unsigned DEFAULT_DEST = 0
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef RMT_STATS_EN
    input  logic                           stat_clr,
    output logic [STAT_WIDTH-1:0]          stat_fwd_pkts,
    output logic [STAT_WIDTH-1:0]          stat_drop_pkts,
    output logic [STAT_WIDTH-1:0]          stat_miss_pkts,
`endif
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic [USER_WIDTH-1:0]          s_axis_tuser,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    output logic [DEST_WIDTH-1:0]          m_axis_tdest,
    input  logic                           cfg_wr_en,
    input  logic [$clog2(TABLE_DEPTH)-1:0] cfg_addr,
    input  logic                           cfg_valid,
    input  logic [RMT_FUNC_WIDTH-1:0]      cfg_func,
    input  logic [DEST_WIDTH-1:0]          cfg_dest
);
    rmt_state_e              state_q;
    logic [DEST_WIDTH-1:0]   frame_dest_q;

    logic [15:0]             etype;
    logic [15:0]             delim;
    logic [RMT_FUNC_WIDTH-1:0] func;
    logic                    hdr_ok;
    logic                    tbl_hit;
    logic [DEST_WIDTH-1:0]   tbl_dest;
    logic                    first_fwd;
    logic [DEST_WIDTH-1:0]   first_dest;
    logic                    accept;
    logic                    out_load;
    logic [DEST_WIDTH-1:0]   out_dest;

    // Little-endian byte lanes: byte k is tdata[8k +: 8].
    assign etype = s_axis_tdata[8*ETYPE_OFFSET +: 16];
    assign delim = s_axis_tdata[8*DELIM_OFFSET +: 16];
    assign func  = s_axis_tdata[8*FUNC_OFFSET +: RMT_FUNC_WIDTH];

    rmt_match_table #(
        .TABLE_DEPTH (TABLE_DEPTH),
        .DEST_WIDTH  (DEST_WIDTH)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (cfg_wr_en),
        .wr_addr     (cfg_addr),
        .wr_valid    (cfg_valid),
        .wr_func     (cfg_func),
        .wr_dest     (cfg_dest),
        .lookup_func (func),
        .hit         (tbl_hit),
        .hit_dest    (tbl_dest)
    );

    assign hdr_ok     = (etype == ETYPE_MATCH) && (delim == DELIM_MATCH);
    assign first_fwd  = hdr_ok && (tbl_hit || (MISS_DROP == 0));
    assign first_dest = tbl_hit ? tbl_dest : DEST_WIDTH'(DEFAULT_DEST);

    // Dropped beats never touch the output register, so DROP never stalls.
    assign s_axis_tready = (state_q == StDrop) || !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        out_load = accept && (((state_q == StIdle) && first_fwd) || (state_q == StFwd));
        out_dest = (state_q == StIdle) ? first_dest : frame_dest_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            frame_dest_q  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tdest  <= '0;
        end else begin
            if (out_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tuser  <= s_axis_tuser;
                m_axis_tdest  <= out_dest;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (accept) begin
                unique case (state_q)
                    StIdle: begin
                        if (first_fwd) begin
                            frame_dest_q <= first_dest;
                            if (!s_axis_tlast) state_q <= StFwd;
                        end else if (!s_axis_tlast) begin
                            state_q <= StDrop;
                        end
                    end
                    StFwd:   if (s_axis_tlast) state_q <= StIdle;
                    StDrop:  if (s_axis_tlast) state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef RMT_STATS_EN
    logic classify;
    assign classify = accept && (state_q == StIdle);

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_fwd_pkts  <= '0;
            stat_drop_pkts <= '0;
            stat_miss_pkts <= '0;
        end else if (classify) begin
            if (first_fwd) stat_fwd_pkts  <= sat_inc(stat_fwd_pkts);
            else           stat_drop_pkts <= sat_inc(stat_drop_pkts);
            if (hdr_ok && !tbl_hit) stat_miss_pkts <= sat_inc(stat_miss_pkts);
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_rmt_match_router.sv
module tb_rmt_match_router;
    localparam int unsigned DW = 512;
    localparam int unsigned KW = DW / 8;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] s_data;
    logic [KW-1:0] s_keep;
    logic          s_valid, s2_valid, s_last;
    logic [0:0]    s_user;
    logic          s_ready, s2_ready;
    logic [DW-1:0] m_data, m2_data;
    logic [KW-1:0] m_keep, m2_keep;
    logic          m_valid, m2_valid, m_ready, m_last, m2_last;
    logic [0:0]    m_user, m2_user;
    logic [1:0]    m_dest, m2_dest;
    logic          cfg_wr_en, cfg_valid;
    logic [1:0]    cfg_addr, cfg_dest;
    logic [15:0]   cfg_func;
    logic          stat_clr;
`ifdef RMT_STATS_EN
    logic [31:0]   st_fwd, st_drop, st_miss, st2_fwd, st2_drop, st2_miss;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rmt_match_router #(.MISS_DROP(0), .DEFAULT_DEST(2)) dut (
        .clk(clk), .rst(rst),
`ifdef RMT_STATS_EN
        .stat_clr(stat_clr), .stat_fwd_pkts(st_fwd), .stat_drop_pkts(st_drop),
        .stat_miss_pkts(st_miss),
`endif
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(m_last), .m_axis_tuser(m_user),
        .m_axis_tdest(m_dest),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .cfg_func(cfg_func), .cfg_dest(cfg_dest)
    );

    rmt_match_router #(.MISS_DROP(1), .DEFAULT_DEST(2)) dut_drop (
        .clk(clk), .rst(rst),
`ifdef RMT_STATS_EN
        .stat_clr(stat_clr), .stat_fwd_pkts(st2_fwd), .stat_drop_pkts(st2_drop),
        .stat_miss_pkts(st2_miss),
`endif
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s2_valid),
        .s_axis_tready(s2_ready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
        .m_axis_tdata(m2_data), .m_axis_tkeep(m2_keep), .m_axis_tvalid(m2_valid),
        .m_axis_tready(1'b1), .m_axis_tlast(m2_last), .m_axis_tuser(m2_user),
        .m_axis_tdest(m2_dest),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .cfg_func(cfg_func), .cfg_dest(cfg_dest)
    );

    function automatic logic [DW-1:0] hdr(input logic [15:0] et, input logic [15:0] dl,
                                          input logic [15:0] fn, input logic [7:0] tag);
        logic [DW-1:0] d;
        d = '0;
        d[8*12 +: 16]  = et;
        d[8*42 +: 16]  = dl;
        d[8*44 +: 16]  = fn;
        d[7:0]         = tag;
        d[DW-1 -: 8]   = ~tag;
        return d;
    endfunction

    function automatic logic [DW-1:0] body(input logic [7:0] tag);
        return {64{tag}};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_beat(input string tag, input logic [DW-1:0] d, input logic l,
                            input logic [1:0] dst);
        chk1({tag, "_valid"}, m_valid, 1'b1);
        chkd({tag, "_data"}, m_data, d);
        chk1({tag, "_last"}, m_last, l);
        chk32({tag, "_dest"}, 32'(m_dest), 32'(dst));
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic v, input logic [15:0] f,
                             input logic [1:0] dst);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_valid = v; cfg_func = f; cfg_dest = dst;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    logic [DW-1:0] fr [4];
    logic [DW-1:0] held;
    logic          stalled;
    int            in_idx, out_idx;

    initial begin
        rst = 1'b1; s_data = '0; s_keep = '1; s_valid = 1'b0; s2_valid = 1'b0;
        s_last = 1'b0; s_user = 1'b0; m_ready = 1'b1; stat_clr = 1'b0;
        cfg_wr_en = 1'b0; cfg_addr = '0; cfg_valid = 1'b0; cfg_func = '0; cfg_dest = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk1("rst_valid", m_valid, 1'b0);
        chkd("rst_data", m_data, '0);
        chk1("rst_last", m_last, 1'b0);
        chk32("rst_dest", 32'(m_dest), 32'd0);
        chk1("rst_ready", s_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Matched 3-beat frame, 1-cycle latency, tdest=1 on every beat
        cfg_write(2'd0, 1'b1, 16'h0001, 2'd1);
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0001, 8'hA0); s_last = 1'b0; s_valid = 1'b1;
        #1 chk1("t1_pre", m_valid, 1'b0);
        @(negedge clk);
        exp_beat("t1_b0", hdr(16'h0008, 16'hF0E1, 16'h0001, 8'hA0), 1'b0, 2'd1);
        s_data = body(8'hA1);
        @(negedge clk);
        exp_beat("t1_b1", body(8'hA1), 1'b0, 2'd1);
        s_data = body(8'hA2); s_last = 1'b1;
        @(negedge clk);
        exp_beat("t1_b2", body(8'hA2), 1'b1, 2'd1);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk1("t1_idle", m_valid, 1'b0);

        // Miss, forward to DEFAULT_DEST
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0007, 8'hB0); s_last = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        exp_beat("t2_def", hdr(16'h0008, 16'hF0E1, 16'h0007, 8'hB0), 1'b1, 2'd2);
        s_valid = 1'b0; s_last = 1'b0;

        // Miss with MISS_DROP=1: 2-beat frame dropped, ready held high
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0007, 8'hB1); s2_valid = 1'b1;
        #1 chk1("t2_rdy0", s2_ready, 1'b1);
        @(negedge clk);
        chk1("t2_drop0", m2_valid, 1'b0);
        s_data = body(8'hB2); s_last = 1'b1;
        #1 chk1("t2_rdy1", s2_ready, 1'b1);
        @(negedge clk);
        chk1("t2_drop1", m2_valid, 1'b0);
        s2_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk1("t2_drop2", m2_valid, 1'b0);
`ifdef RMT_STATS_EN
        chk32("t2_st2_miss", st2_miss, 32'd1);
        chk32("t2_st2_drop", st2_drop, 32'd1);
        chk32("t2_st2_fwd", st2_fwd, 32'd0);
        chk32("t2_st_fwd", st_fwd, 32'd2);
        chk32("t2_st_miss", st_miss, 32'd1);
        chk32("t2_st_drop", st_drop, 32'd0);
`endif

        // Bad EtherType single beat, bad-delimiter 2-beat frame whose tail looks
        // like a header, then a good frame back-to-back
        s_data = hdr(16'h0608, 16'hF0E1, 16'h0001, 8'hC0); s_last = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        chk1("t3_bad_et", m_valid, 1'b0);
        s_data = hdr(16'h0008, 16'h1234, 16'h0001, 8'hC1); s_last = 1'b0;
        @(negedge clk);
        chk1("t3_bad_dl0", m_valid, 1'b0);
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0001, 8'hC2); s_last = 1'b1;
        @(negedge clk);
        chk1("t3_bad_dl1", m_valid, 1'b0);
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0001, 8'hC3); s_last = 1'b1;
        @(negedge clk);
        exp_beat("t3_good", hdr(16'h0008, 16'hF0E1, 16'h0001, 8'hC3), 1'b1, 2'd1);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk1("t3_idle", m_valid, 1'b0);

        // Backpressure 1010... during a 4-beat matched frame
        fr[0] = hdr(16'h0008, 16'hF0E1, 16'h0001, 8'hD0);
        fr[1] = body(8'hD1); fr[2] = body(8'hD2); fr[3] = body(8'hD3);
        in_idx = 0; out_idx = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
            if (stalled) chkd("t4_hold", m_data, held);
            m_ready = (cyc % 2 == 0);
            if (in_idx < 4) begin
                s_valid = 1'b1; s_data = fr[in_idx]; s_last = (in_idx == 3);
            end else begin
                s_valid = 1'b0; s_last = 1'b0;
            end
            #1;
            stalled = m_valid && !m_ready;
            held    = m_data;
            if (m_valid && m_ready) begin
                chkd("t4_data", m_data, fr[out_idx]);
                chk32("t4_dest", 32'(m_dest), 32'd1);
                chk1("t4_last", m_last, out_idx == 3);
                out_idx++;
            end
            if (s_valid && s_ready) in_idx++;
            @(negedge clk);
        end
        chk32("t4_count", out_idx, 32'd4);
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        chk1("t4_nodup", m_valid, 1'b0);

        // Priority: entries 1 and 3 share func 2, lowest index wins
        cfg_write(2'd1, 1'b1, 16'h0002, 2'd3);
        cfg_write(2'd3, 1'b1, 16'h0002, 2'd1);
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hE0); s_last = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        exp_beat("t5_prio", hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hE0), 1'b1, 2'd3);
        // Rewrite entry 1 on the first-beat cycle: lookup sees the old dest
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hE1);
        cfg_wr_en = 1'b1; cfg_addr = 2'd1; cfg_valid = 1'b1; cfg_func = 16'h0002;
        cfg_dest = 2'd0;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        exp_beat("t5_old", hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hE1), 1'b1, 2'd3);
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hE2);
        @(negedge clk);
        exp_beat("t5_new", hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hE2), 1'b1, 2'd0);
        // Mid-frame write does not disturb the latched tdest
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0001, 8'hE3); s_last = 1'b0;
        @(negedge clk);
        exp_beat("t5_mf0", hdr(16'h0008, 16'hF0E1, 16'h0001, 8'hE3), 1'b0, 2'd1);
        s_data = body(8'hE4); s_last = 1'b1;
        cfg_wr_en = 1'b1; cfg_addr = 2'd0; cfg_valid = 1'b1; cfg_func = 16'h0001;
        cfg_dest = 2'd2;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        exp_beat("t5_mf1", body(8'hE4), 1'b1, 2'd1);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);

        // Reset mid-frame in FWD
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hF0); s_last = 1'b0; s_valid = 1'b1;
        @(negedge clk);
        exp_beat("t6_b0", hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hF0), 1'b0, 2'd0);
        s_data = body(8'hF1); rst = 1'b1;
        @(negedge clk);
        chk1("t6_rst_valid", m_valid, 1'b0);
        chkd("t6_rst_data", m_data, '0);
        rst = 1'b0;
        // A bad header is dropped only if the FSM really returned to IDLE
        s_data = hdr(16'h0608, 16'hF0E1, 16'h0002, 8'hF2); s_last = 1'b1;
        @(negedge clk);
        chk1("t6_idle", m_valid, 1'b0);
        // Table is empty after reset: miss goes to DEFAULT_DEST
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hF3);
        @(negedge clk);
        exp_beat("t6_empty", hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hF3), 1'b1, 2'd2);
        s_valid = 1'b0; s_last = 1'b0;
`ifdef RMT_STATS_EN
        chk32("t6_st_fwd", st_fwd, 32'd1);
        chk32("t6_st_drop", st_drop, 32'd1);
        chk32("t6_st_miss", st_miss, 32'd1);
`endif
        @(negedge clk);
        cfg_write(2'd0, 1'b1, 16'h0002, 2'd3);
        s_data = hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hF4); s_last = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        exp_beat("t6_route", hdr(16'h0008, 16'hF0E1, 16'h0002, 8'hF4), 1'b1, 2'd3);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk1("t6_end", m_valid, 1'b0);

`ifdef RMT_STATS_EN
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk32("t7_clr_fwd", st_fwd, 32'd0);
        chk32("t7_clr_miss", st2_miss, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rmt_match_router.md
Name: rmt_match_router

Overview:
- Single-port AXI-Stream ingress classifier/router for the application datapath.
- Parses the first beat of each frame and checks the EtherType and the protocol delimiter.
- Looks up the function-type field in a small runtime-programmable match table, then forwards the whole frame with a per-frame tdest or drops it.
- Next-generation replacement for the fixed single-rule classifier. Adds:
  - a configurable table
  - a miss policy
  - a proper registered output stage with backpressure

Parameters:
- DATA_WIDTH, 512, tdata width; must be ≥ 8*(FUNC_OFFSET+2).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 1, tuser width.
- DEST_WIDTH, 2, tdest width.
- TABLE_DEPTH, 4, number of match entries; must be 2..16.
- ETYPE_OFFSET, 12, byte offset of EtherType.
- DELIM_OFFSET, 42, byte offset of delimiter.
- FUNC_OFFSET, 44, byte offset of function type.
- ETYPE_MATCH, 16'h0008, EtherType value (IPv4, wire byte order).
- DELIM_MATCH, 16'hF0E1, delimiter value.
- MISS_DROP, 0, 1 = drop on table miss; 0 = forward to DEFAULT_DEST.
- DEFAULT_DEST, 0, tdest used on miss when MISS_DROP=0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  DATA_WIDTH  ingress data
- s_axis_tkeep  in  KEEP_WIDTH  ingress keep
- s_axis_tvalid  in  1  ingress valid
- s_axis_tready  out  1  ingress ready
- s_axis_tlast  in  1  ingress last
- s_axis_tuser  in  USER_WIDTH  ingress user
- m_axis_tdata  out  DATA_WIDTH  egress data
- m_axis_tkeep  out  KEEP_WIDTH  egress keep
- m_axis_tvalid  out  1  egress valid
- m_axis_tready  in  1  egress ready
- m_axis_tlast  out  1  egress last
- m_axis_tuser  out  USER_WIDTH  egress user
- m_axis_tdest  out  DEST_WIDTH  egress dest, constant across a frame
- cfg_wr_en  in  1  table write strobe
- cfg_addr  in  $clog2(TABLE_DEPTH)  entry index
- cfg_valid  in  1  entry enable
- cfg_func  in  16  function-type key
- cfg_dest  in  DEST_WIDTH  entry destination

Behaviour:
- Single clock clk; rst is synchronous, active-high.
- Reset state:
  - m_axis_tvalid=0 and all other m_axis_* outputs 0
  - state=IDLE
  - all table entries invalid
  - stats counters 0
- s_axis_tready:
  - in DROP: always 1
  - otherwise: !m_axis_tvalid || m_axis_tready (single output register; no combinational path from s_axis to m_axis).
- Latency: 1 cycle from accepted ingress beat to m_axis_tvalid. Full throughput of 1 beat/cycle under continuous m_axis_tready.
- Output register holds data stable while m_axis_tvalid && !m_axis_tready.
- FSM, state IDLE:
  - On an accepted beat, compute hdr_ok = (EtherType==ETYPE_MATCH) && (delimiter==DELIM_MATCH).
  - Lookup: lowest-index valid entry whose cfg_func equals the function-type field wins.
  - Forward when hdr_ok and (hit, or MISS_DROP=0); tdest = entry dest on hit, DEFAULT_DEST on miss. Latch tdest, register the beat to the output, go to FWD if !tlast, else stay in IDLE.
  - Otherwise the beat is discarded; go to DROP if !tlast, else stay in IDLE.
- FSM, state FWD: each accepted beat is registered to the output with the latched tdest; tlast returns to IDLE.
- FSM, state DROP: beats are accepted and discarded; tlast returns to IDLE.
- Single-beat frames (tlast on the first beat) are classified and complete in IDLE.
- Field extraction uses little-endian byte lanes: byte k = tdata[8k+:8].
- The header is decided on the first beat only; tkeep is not checked for header presence.
- Table writes:
  - Take effect on the cycle after cfg_wr_en.
  - A lookup in the same cycle as a write sees the old contents.
  - Writes are legal mid-frame; the latched tdest is unaffected.
- Reset mid-frame: the output is cleared immediately and the FSM returns to IDLE. The next accepted beat is treated as a frame start; upstream is reset together with this block.

Optional Feature:
- Macro RMT_STATS_EN.
- Defined: adds outputs stat_fwd_pkts[31:0], stat_drop_pkts[31:0], stat_miss_pkts[31:0].
  - Each increments once per frame, on the first beat's classification.
  - Each saturates at 32'hFFFFFFFF.
  - stat_miss_pkts counts table misses with hdr_ok, whether forwarded or dropped.
  - Synchronous clear via input stat_clr (priority over increment).
- Undefined: ports and counters absent; no other behavioural difference.

Decomposition:
- Package rmt_pkg:
  - state encodings IDLE=0, FWD=1, DROP=2
  - default header offsets and match constants
  - the stats counter width
- Sub-module rmt_match_table:
  - register array of {valid, func, dest}
  - write port
  - combinational priority lookup returning hit and dest

Test Plan:
- Entry0={func 0x0001, dest 1}; 3-beat frame with EtherType 0x0008, delimiter 0xF0E1, func 0x0001 → 3 beats out, tdest=1 on all beats, last beat tlast, 1-cycle latency.
- Func 0x0007, no entry, MISS_DROP=0, DEFAULT_DEST=2 → forwarded with tdest=2. Same with MISS_DROP=1 → 0 output beats, s_axis_tready stays 1, stat_miss_pkts=1.
- EtherType 0x0608 single-beat frame, then a valid frame back-to-back → only the second frame appears; no bubble required.
- m_axis_tready toggled 1010… during a 4-beat matched frame → no beat lost or duplicated; data stable while stalled.
- Entries 1 and 3 both hold func 0x0002 (dests 3, 1) → tdest=3. Rewrite entry1 on the first-beat cycle → the lookup uses the old value.
- rst asserted in FWD mid-frame → next cycle m_axis_tvalid=0, state IDLE; the next valid frame routes correctly; table entries are invalid after reset.
